// File: rtl/div_unit_pkg.sv
// Shared constants, state encodings and helpers for the HI/LO divider.
package div_unit_pkg;

  localparam int RegBus = 32;

  localparam logic [RegBus-1:0] ZeroWord      = '0;
  // Quotient returned for any divide by zero, signed or unsigned.
  localparam logic [RegBus-1:0] DivByZeroQuot = '1;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    DivFree = 2'b00,
    DivOn   = 2'b01,
    DivEnd  = 2'b10
  } div_state_e;

  // Two's-complement negate when neg is set; used both to take operand
  // magnitudes and to restore result signs.
  function automatic logic [RegBus-1:0] cond_neg(input logic [RegBus-1:0] v,
                                                 input logic              neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the execute stage and the divider.
interface div_unit_if;
  import div_unit_pkg::*;

  logic              start;
  logic              signed_div;
  logic [RegBus-1:0] dividend;
  logic [RegBus-1:0] divisor;
  logic              annul;
  logic              busy;
  logic              ready;
  logic [RegBus-1:0] hi_o;
  logic [RegBus-1:0] lo_o;

  modport master (
    output start, signed_div, dividend, divisor, annul,
    input  busy, ready, hi_o, lo_o
  );

  modport slave (
    input  start, signed_div, dividend, divisor, annul,
    output busy, ready, hi_o, lo_o
  );

endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider producing remainder (HI) and quotient (LO)
// for DIV/DIVU, one quotient bit per cycle on operand magnitudes.
//
//   state   | meaning
//   DivFree | idle, waiting for a start request
//   DivOn   | iterating, one quotient bit per cycle
//   DivEnd  | result presented on hi_o/lo_o, ready pulses
module div_unit
  import div_unit_pkg::*;
(
  input logic       cpu_clk_75M,
  input logic       cpu_rst,
  div_unit_if.slave div
);

  div_state_e          state_q;
  logic [5:0]          cnt_q;
  // Held pre-shifted: [64:32] is the partial remainder already shifted with
  // the next dividend bit, [31:1] the remaining dividend bits followed by
  // quotient bits, [0] the empty slot for this cycle's quotient bit.
  logic [2*RegBus:0]   rq_q;
  logic [2*RegBus:0]   rq_d;
  logic [RegBus-1:0]   dvs_q;
  logic [RegBus-1:0]   hi_q;
  logic [RegBus-1:0]   lo_q;
  logic                neg_rem_q;
  logic                neg_quo_q;

  logic                op_neg_dvd;
  logic                op_neg_dvs;
  logic [RegBus-1:0]   dvd_mag;
  logic [RegBus-1:0]   dvs_mag;
  logic [RegBus:0]     trial;
  logic                ge;
  logic [RegBus-1:0]   rem_nx;
  logic [2*RegBus-1:0] unsh;

  // Operand sign detection and magnitudes at request time.
  always_comb begin
    op_neg_dvd = div.signed_div & div.dividend[RegBus-1];
    op_neg_dvs = div.signed_div & div.divisor[RegBus-1];
    dvd_mag    = cond_neg(div.dividend, op_neg_dvd);
    dvs_mag    = cond_neg(div.divisor, op_neg_dvs);
  end

  // One restoring step: 33-bit trial subtract, keep or restore, then
  // pre-shift for the next iteration.
  always_comb begin
    trial  = rq_q[2*RegBus:RegBus] - {1'b0, dvs_q};
    ge     = ~trial[RegBus];
    // A kept difference is always below the divisor, so its top bit is zero.
    rem_nx = ge ? trial[RegBus-1:0] : rq_q[2*RegBus-1:RegBus];
    unsh   = {rem_nx, rq_q[RegBus-1:1], rq_q[0] | ge};
    rq_d   = {unsh, 1'b0};
  end

  // Controller and datapath registers; sign fix-up is applied on the last
  // iteration so hi/lo are final when DivEnd is entered.
  always_ff @(posedge cpu_clk_75M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      rq_q      <= '0;
      dvs_q     <= ZeroWord;
      hi_q      <= ZeroWord;
      lo_q      <= ZeroWord;
      neg_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
    end else begin
      case (state_q)
        DivFree: begin
          if (div.start && !div.annul) begin
            if (div.divisor == ZeroWord) begin
              hi_q    <= div.dividend;
              lo_q    <= DivByZeroQuot;
              state_q <= DivEnd;
            end else begin
              rq_q      <= {ZeroWord, dvd_mag, 1'b0};
              dvs_q     <= dvs_mag;
              neg_rem_q <= op_neg_dvd;
              neg_quo_q <= op_neg_dvd ^ op_neg_dvs;
              cnt_q     <= '0;
              state_q   <= DivOn;
            end
          end
        end
        DivOn: begin
          if (div.annul) begin
            state_q <= DivFree;
          end else begin
            rq_q  <= rq_d;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
              hi_q    <= cond_neg(unsh[2*RegBus-1:RegBus], neg_rem_q);
              lo_q    <= cond_neg(unsh[RegBus-1:0], neg_quo_q);
              state_q <= DivEnd;
            end
          end
        end
        DivEnd:  state_q <= DivFree;
        default: state_q <= DivFree;
      endcase
    end
  end

  // Status decode; ready is suppressed by annul so a flushed op never
  // writes HILO.
  assign div.busy  = (state_q != DivFree);
  assign div.ready = (state_q == DivEnd && !div.annul) ? DivResultReady
                                                       : DivResultNotReady;
  assign div.hi_o  = hi_q;
  assign div.lo_o  = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit with hand-computed results.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk;
  logic rst;
  div_unit_if dif();

  div_unit dut (
    .cpu_clk_75M(clk),
    .cpu_rst    (rst),
    .div        (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int cyc_cnt = 0;
  int t0 = 0;
  int rdy_n = 0;
  int busy_n = 0;
  int rdy_rel = 0;
  logic [31:0] rdy_hi = '0;
  logic [31:0] rdy_lo = '0;
  int rdy_base = 0;
  int busy_base = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Sample outputs mid-cycle; inputs change just after the rising edge.
  always @(negedge clk) begin
    if (dif.ready) begin
      rdy_n   <= rdy_n + 1;
      rdy_rel <= cyc_cnt - t0;
      rdy_hi  <= dif.hi_o;
      rdy_lo  <= dif.lo_o;
    end
    if (dif.busy) busy_n <= busy_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic sd, input logic [31:0] a, input logic [31:0] b);
    tick();
    t0             = cyc_cnt;
    rdy_base       = rdy_n;
    busy_base      = busy_n;
    dif.start      = 1'b1;
    dif.signed_div = sd;
    dif.dividend   = a;
    dif.divisor    = b;
    tick();
    dif.start      = 1'b0;
    dif.dividend   = 32'h0;
    dif.divisor    = 32'h0;
  endtask

  // Runs one divide, optionally pulsing a competing start at cycle poke.
  task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int exp_cyc, input int poke);
    int n;
    launch(sd, a, b);
    n = 0;
    while (rdy_n == rdy_base && n < 60) begin
      tick();
      n++;
      if (poke > 0 && cyc_cnt == t0 + poke) begin
        dif.start      = 1'b1;
        dif.signed_div = 1'b1;
        dif.dividend   = 32'd50;
        dif.divisor    = 32'd5;
      end else begin
        dif.start = 1'b0;
      end
    end
    dif.start = 1'b0;
    chk({tag, "_seen"}, 32'(rdy_n != rdy_base), 32'd1);
    repeat (3) tick();
    chk({tag, "_cyc"},   32'(rdy_rel), 32'(exp_cyc));
    chk({tag, "_lo"},    rdy_lo, exp_lo);
    chk({tag, "_hi"},    rdy_hi, exp_hi);
    chk({tag, "_pulse"}, 32'(rdy_n - rdy_base), 32'd1);
    chk({tag, "_busy"},  32'(busy_n - busy_base), 32'(exp_cyc));
  endtask

  task automatic annul_test(input string tag, input int at);
    launch(1'b0, 32'd100, 32'd7);
    while (cyc_cnt < t0 + at) tick();
    dif.annul = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy"},  32'(dif.ready), 32'd0);
    chk({tag, "_bsy"},  32'(dif.busy), 32'd1);
    tick();
    dif.annul = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, 32'(dif.busy), 32'd0);
    repeat (40) tick();
    chk({tag, "_none"}, 32'(rdy_n - rdy_base), 32'd0);
    run_div({tag, "_9_3"}, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    dif.start      = 1'b0;
    dif.signed_div = 1'b0;
    dif.dividend   = 32'h0;
    dif.divisor    = 32'h0;
    dif.annul      = 1'b0;
    #3;
    chk("rst_hi",    dif.hi_o, 32'h0);
    chk("rst_lo",    dif.lo_o, 32'h0);
    chk("rst_busy",  32'(dif.busy), 32'd0);
    chk("rst_ready", 32'(dif.ready), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    run_div("u100_7",  1'b0, 32'd100,        32'd7,        32'd14,        32'd2,         33, 0);
    run_div("s_m7_2",  1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD,  32'hFFFFFFFF,  33, 0);
    run_div("u_fff9",  1'b0, 32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC,  32'd1,         33, 0);
    run_div("s7_m2",   1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,  32'd1,         33, 0);
    run_div("s5_0",    1'b1, 32'd5,          32'd0,        32'hFFFFFFFF,  32'd5,         1,  0);
    run_div("u5_0",    1'b0, 32'd5,          32'd0,        32'hFFFFFFFF,  32'd5,         1,  0);
    run_div("s_ovf",   1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,  32'd0,         33, 0);
    run_div("u_max_1", 1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,  32'd0,         33, 0);
    run_div("poke5",   1'b0, 32'd100,        32'd7,        32'd14,        32'd2,         33, 5);

    annul_test("annul10", 10);
    annul_test("annul33", 33);

    // annul outranks start in idle: the request is dropped
    tick();
    rdy_base       = rdy_n;
    dif.start      = 1'b1;
    dif.annul      = 1'b1;
    dif.signed_div = 1'b0;
    dif.dividend   = 32'd9;
    dif.divisor    = 32'd3;
    tick();
    dif.start = 1'b0;
    dif.annul = 1'b0;
    @(negedge clk);
    chk("idle_annul_busy", 32'(dif.busy), 32'd0);
    repeat (40) tick();
    chk("idle_annul_none", 32'(rdy_n - rdy_base), 32'd0);

    // asynchronous reset mid-calculation; lo still holds 3 from 9/3
    launch(1'b0, 32'd100, 32'd7);
    while (cyc_cnt < t0 + 20) tick();
    chk("pre_rst_busy", 32'(dif.busy), 32'd1);
    chk("pre_rst_lo",   dif.lo_o, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_hi",    dif.hi_o, 32'h0);
    chk("arst_lo",    dif.lo_o, 32'h0);
    chk("arst_busy",  32'(dif.busy), 32'd0);
    chk("arst_ready", 32'(dif.ready), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (40) tick();
    chk("post_rst_none", 32'(rdy_n - rdy_base), 32'd0);
    chk("post_rst_busy", 32'(dif.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
